// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_responder
// Brief    : Serialises single-cycle MIPS fetch and load/store onto one
//            single-port synchronous word RAM, stalling the CPU until done.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_responder #(
    parameter int dwidth = 32,
    parameter int awidth = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [dwidth-1:0] if_addr,
    output logic [dwidth-1:0] if_rdata,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [dwidth-1:0] d_addr,
    input  logic [dwidth-1:0] d_wdata,
    output logic [dwidth-1:0] d_rdata,
    output logic              stall,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [awidth-1:0] mem_addr,
    output logic [dwidth-1:0] mem_wdata,
    input  logic [dwidth-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        D_WAIT  = 3'd1,
        I_ISSUE = 3'd2,
        I_WAIT  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [dwidth-1:0] if_rdata_q, if_rdata_d;
    logic [dwidth-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;

    logic              w_issue;
    logic              w_write;
    logic              w_use_daddr;
    logic              w_both_rw;
    logic              w_stall;
    logic [dwidth-1:0] w_issue_addr;
    logic              w_unused;

    always_comb begin
        state_d     = state_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        w_issue     = 1'b0;
        w_write     = 1'b0;
        w_use_daddr = 1'b0;
        w_both_rw   = 1'b0;
        w_stall     = 1'b1;

        case (state_q)
            IDLE: begin
                // Data goes first so a store-then-fetch sees the new word.
                if (d_we) begin
                    w_issue     = 1'b1;
                    w_write     = 1'b1;
                    w_use_daddr = 1'b1;
                    w_both_rw   = d_re;
                    state_d     = if_req ? I_ISSUE : DONE;
                end else if (d_re) begin
                    w_issue     = 1'b1;
                    w_use_daddr = 1'b1;
                    state_d     = D_WAIT;
                end else if (if_req) begin
                    w_issue = 1'b1;
                    state_d = I_WAIT;
                end else begin
                    w_stall = 1'b0;
                end
            end
            D_WAIT: begin
                d_rdata_d = mem_rdata;
                state_d   = if_req ? I_ISSUE : DONE;
            end
            I_ISSUE: begin
                w_issue = 1'b1;
                state_d = I_WAIT;
            end
            I_WAIT: begin
                if_rdata_d = mem_rdata;
                state_d    = DONE;
            end
            DONE: begin
                w_stall = 1'b0;
                state_d = IDLE;
            end
            default: begin
                w_stall = 1'b0;
                state_d = IDLE;
            end
        endcase

        w_issue_addr = w_use_daddr ? d_addr : if_addr;
        err_d        = err_q | (w_issue & ((w_issue_addr[1:0] != 2'b00) | w_both_rw));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
        end
    end

    // Reset gates the RAM strobes so a reset cycle can never write.
    assign mem_en    = w_issue & ~reset;
    assign mem_we    = w_write & ~reset;
    assign stall     = w_stall & ~reset;
    assign mem_addr  = w_issue_addr[awidth+1:2];
    assign mem_wdata = d_wdata;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;

    assign w_unused = ^w_issue_addr[dwidth-1:awidth+2];

endmodule
`default_nettype wire

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
Memory-side responder for the single-cycle MIPS datapath. It serves the CPU's instruction fetch (pc) and its data load/store (alumult_out address, writedata, readdata) from one single-port synchronous word RAM with 1-cycle read latency. A state machine serialises the accesses and asserts stall to freeze the CPU until the fetch and any data access for the current instruction have both completed.

Parameters:
- dwidth, 32, data word width in bits.
- awidth, 10, RAM word-address width (RAM holds 2^awidth words).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous reset, active-high.
- if_req  input  1  instruction fetch requested this instruction.
- if_addr  input  dwidth  byte address of the fetch (the CPU pc).
- if_rdata  output  dwidth  registered fetched instruction.
- d_re  input  1  data load request.
- d_we  input  1  data store request.
- d_addr  input  dwidth  data byte address (the CPU alumult_out).
- d_wdata  input  dwidth  store data (the CPU writedata).
- d_rdata  output  dwidth  registered load data (the CPU readdata).
- stall  output  1  CPU must hold the pc and all request inputs stable and must not commit state.
- err  output  1  sticky protocol/alignment error.
- mem_en  output  1  RAM access enable.
- mem_we  output  1  RAM write enable (only with mem_en).
- mem_addr  output  awidth  RAM word address = byte address bits [awidth+1:2].
- mem_wdata  output  dwidth  RAM write data = d_wdata.
- mem_rdata  input  dwidth  RAM read data, valid the cycle after a read issue.

Behaviour:
- Reset values: state IDLE; if_rdata=0, d_rdata=0, err=0. While reset=1: stall=0, and mem_en=mem_we=0 (gated combinationally), so no RAM write occurs in a reset cycle. A reset mid-transaction abandons it and discards any captured data.
- The CPU holds all request inputs constant while stall=1. The responder samples them in every state.
- d_req = d_re | d_we. Data is served before the fetch.
- States and transitions:
  - IDLE:
    - If d_we: issue a write (mem_en=1, mem_we=1, mem_addr from d_addr); next state I_ISSUE if if_req, else DONE.
    - Else if d_re: issue a read; next state D_WAIT.
    - Else if if_req: issue a fetch read; next state I_WAIT.
    - Else: stay in IDLE.
  - D_WAIT: d_rdata <= mem_rdata; next state I_ISSUE if if_req, else DONE.
  - I_ISSUE: issue the fetch read (mem_en=1, mem_addr from if_addr); next state I_WAIT.
  - I_WAIT: if_rdata <= mem_rdata; next state DONE.
  - DONE: stall=0, no RAM access; next state IDLE. The CPU commits on this edge.
- stall = 1 except in DONE, and except in IDLE when no request is present.
- Latency from request to the DONE cycle:
  - fetch only: 2 cycles
  - store + fetch: 3 cycles
  - load + fetch: 4 cycles
  - load only: 2 cycles
  - store only: 1 cycle
- mem_en=0 and mem_we=0 in D_WAIT, I_WAIT, DONE, and in IDLE when idle.
- if_rdata and d_rdata hold their last captured values until overwritten. A store does not modify d_rdata.
- Address rules:
  - Bits [1:0] are ignored for addressing.
  - Bits above awidth+1 are ignored, so addresses wrap modulo 2^awidth words.
- err is set, and stays set until reset, in any cycle where a request is issued and any of these holds:
  - the issued address has bits [1:0] != 0;
  - d_re=1 and d_we=1 together (treated as a store).
- Store-then-fetch to the same word: the fetch returns the newly written data (the write is issued one or more cycles earlier).

Test Plan:
- Reset, then if_req=1, if_addr=0x8, RAM[2]=0x20080005 -> mem_en=1 and mem_addr=2 in cycle 0; stall=1 in cycles 0–1; if_rdata=0x20080005 and stall=0 in cycle 2.
- Load with d_addr=0x40 (RAM[16]=0xDEADBEEF), if_addr=0x4 (RAM[1]=0x1) -> data read issued cycle 0, fetch issued cycle 2, DONE in cycle 4; d_rdata=0xDEADBEEF, if_rdata=0x1.
- Store with d_addr=0xC, d_wdata=0xCAFEF00D, if_addr=0xC -> mem_we=1 only in cycle 0; if_rdata=0xCAFEF00D at DONE in cycle 3; err=0.
- d_addr=0x42 store, and a separate case with d_re=d_we=1 -> write goes to word 16; err=1 and remains 1 through further clean transactions until reset.
- Assert reset in the D_WAIT cycle of a load -> next cycle state IDLE, stall=0, d_rdata=0, and no mem_we pulse at any point.
- if_addr=0x1000 with awidth=10 -> mem_addr=0 (wrap); back-to-back fetches of 0x0, 0x4, 0x8 each complete in exactly 3 cycles including the DONE cycle.
